// File: rtl/reg_file_2w2r.sv
// Two-write / two-read register file with write-through bypass, an optional
// hardwired-zero entry 0 and a self-clearing sweep after reset.
module reg_file_2w2r #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen0,
  input  logic [ADDR_WIDTH-1:0] waddr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  wen1,
  input  logic [ADDR_WIDTH-1:0] waddr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  ready
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]  START     = (ZERO_REG != 0) ? CNT_WIDTH'(1) : '0;
  localparam logic [CNT_WIDTH-1:0]  LAST      = CNT_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state;
  logic [CNT_WIDTH-1:0]    sweep_cnt;
  logic [DATA_WIDTH-1:0]   regs [DEPTH];
  logic                    run;
  logic                    wr0_ok;
  logic                    wr1_ok;
  logic                    wr0_shadowed;

  function automatic logic is_zero_addr(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == ZERO_ADDR);
  endfunction

  // A write counts only in RUN and never to the hardwired entry; the same
  // qualified enables drive both storage and bypass so they cannot disagree.
  assign run          = (state == RUN);
  assign wr1_ok       = run && wen1 && !is_zero_addr(waddr1);
  assign wr0_ok       = run && wen0 && !is_zero_addr(waddr0);
  assign wr0_shadowed = wr1_ok && (waddr0 == waddr1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_cnt <= START;
      ready     <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          regs[sweep_cnt[ADDR_WIDTH-1:0]] <= '0;
          sweep_cnt <= sweep_cnt + CNT_WIDTH'(1);
          if (sweep_cnt == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (wr0_ok && !wr0_shadowed) regs[waddr0] <= wdata0;
          if (wr1_ok)                  regs[waddr1] <= wdata1;
        end
      endcase
    end
  end

  // Port 1 outranks port 0 on the bypass path, matching the storage priority.
  assign rdata1 = (!run || is_zero_addr(raddr1)) ? '0 :
                  (wr1_ok && (waddr1 == raddr1)) ? wdata1 :
                  (wr0_ok && (waddr0 == raddr1)) ? wdata0 :
                  regs[raddr1];

  assign rdata2 = (!run || is_zero_addr(raddr2)) ? '0 :
                  (wr1_ok && (waddr1 == raddr2)) ? wdata1 :
                  (wr0_ok && (waddr0 == raddr2)) ? wdata0 :
                  regs[raddr2];

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Bench for reg_file_2w2r: default instance checked by vectors and a random
// reference model, plus a 64-bit / 8-entry / no-zero-register instance.
module tb_reg_file_2w2r;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wen0, wen1, ready;
  logic [4:0]  waddr0, waddr1, raddr1, raddr2;
  logic [31:0] wdata0, wdata1, rdata1, rdata2;

  logic        b_rst_n, b_wen0, b_wen1, b_ready;
  logic [2:0]  b_waddr0, b_waddr1, b_raddr1, b_raddr2;
  logic [63:0] b_wdata0, b_wdata1, b_rdata1, b_rdata2;

  reg_file_2w2r dut_a (
    .clk(clk), .rst_n(rst_n),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .ready(ready)
  );

  reg_file_2w2r #(.DATA_WIDTH(64), .ADDR_WIDTH(3), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .wen0(b_wen0), .waddr0(b_waddr0), .wdata0(b_wdata0),
    .wen1(b_wen1), .waddr1(b_waddr1), .wdata1(b_wdata1),
    .raddr1(b_raddr1), .raddr2(b_raddr2),
    .rdata1(b_rdata1), .rdata2(b_rdata2), .ready(b_ready)
  );

  typedef struct {
    logic        wen0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        wen1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: contents become all-zero once 31 non-reset edges have
  // elapsed; afterwards writes land in program order so port 1 wins a tie.
  logic [31:0] m_regs [32];
  bit          m_ready = 1'b0;
  int          m_init_left = 31;

  task automatic modelEdge();
    if (!rst_n) begin
      m_ready     = 1'b0;
      m_init_left = 31;
    end else if (!m_ready) begin
      m_init_left--;
      if (m_init_left == 0) begin
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
      end
    end else begin
      if (wen0 && waddr0 != 5'd0) m_regs[waddr0] = wdata0;
      if (wen1 && waddr1 != 5'd0) m_regs[waddr1] = wdata1;
    end
  endtask

  always @(posedge clk) modelEdge();

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    if (!m_ready || a == 5'd0)     return 32'h0;
    if (wen1 && waddr1 == a)       return wdata1;
    if (wen0 && waddr0 == a)       return wdata0;
    return m_regs[a];
  endfunction

  function automatic vec_t randomVec();
    vec_t v;
    v.wen0   = 1'($urandom_range(0, 1));
    v.waddr0 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    v.wdata0 = $urandom;
    v.wen1   = 1'($urandom_range(0, 1));
    v.waddr1 = ($urandom_range(0, 3) == 0) ? v.waddr0 : 5'($urandom);
    v.wdata1 = $urandom;
    case ($urandom_range(0, 3))
      0:       v.raddr1 = v.waddr0;
      1:       v.raddr1 = v.waddr1;
      2:       v.raddr1 = 5'd0;
      default: v.raddr1 = 5'($urandom);
    endcase
    v.raddr2 = ($urandom_range(0, 1) == 0) ? v.raddr1 : 5'($urandom);
    v.exp1   = '0;
    v.exp2   = '0;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    wen0   = v.wen0;   waddr0 = v.waddr0; wdata0 = v.wdata0;
    wen1   = v.wen1;   waddr1 = v.waddr1; wdata1 = v.wdata1;
    raddr1 = v.raddr1; raddr2 = v.raddr2;
    #1;
  endtask

  task automatic applyB(input logic w0, input logic [2:0] a0, input logic [63:0] d0,
                        input logic w1, input logic [2:0] a1, input logic [63:0] d1,
                        input logic [2:0] r1, input logic [2:0] r2);
    @(negedge clk);
    b_wen0 = w0; b_waddr0 = a0; b_wdata0 = d0;
    b_wen1 = w1; b_waddr1 = a1; b_wdata1 = d1;
    b_raddr1 = r1; b_raddr2 = r2;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [9];
    vec_t v;
    int   a_edge, b_edge, init_bad, b_init_bad;

    vecs[0] = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'h12345678, 32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd7,  32'h12345678, 32'h0};
    vecs[2] = '{1'b1, 5'd7,  32'hAAAA0000, 1'b1, 5'd7,  32'h5555FFFF, 5'd5,  5'd7,  32'h12345678, 32'h5555FFFF};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h5555FFFF, 32'h5555FFFF};
    vecs[4] = '{1'b1, 5'd9,  32'h11,       1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd9,  32'h0,        32'h11};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd9,  32'h0,        32'h11};
    vecs[6] = '{1'b1, 5'd10, 32'hA0,       1'b1, 5'd11, 32'hB1,       5'd10, 5'd11, 32'hA0,       32'hB1};
    vecs[7] = '{1'b1, 5'd0,  32'hDD,       1'b1, 5'd10, 32'hC0,       5'd10, 5'd0,  32'hC0,       32'h0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd10, 5'd11, 32'hC0,       32'hB1};

    rst_n = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; raddr1 = '0; raddr2 = '0;
    b_rst_n = 1'b0; b_wen0 = 1'b0; b_wen1 = 1'b0;
    b_waddr0 = '0; b_waddr1 = '0; b_wdata0 = '0; b_wdata1 = '0; b_raddr1 = '0; b_raddr2 = '0;

    $display("[TB] reset and clear sweep");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", ready, 1'b0);
    checkOutput("reset_b_ready", b_ready, 1'b0);

    // Writes attempted during the sweep must be ignored and reads forced to 0.
    rst_n = 1'b1; b_rst_n = 1'b1;
    wen1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hDEADBEEF;
    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1;
    raddr1 = 5'd3; raddr2 = 5'd0;
    b_wen0 = 1'b1; b_waddr0 = 3'd2; b_wdata0 = 64'hCAFE; b_raddr1 = 3'd2; b_raddr2 = 3'd0;
    a_edge = 0; b_edge = 0; init_bad = 0; b_init_bad = 0;
    for (int e = 1; e <= 40; e++) begin
      if (!ready && (rdata1 !== 32'h0 || rdata2 !== 32'h0)) init_bad++;
      if (!b_ready && (b_rdata1 !== 64'h0 || b_rdata2 !== 64'h0)) b_init_bad++;
      @(posedge clk);
      #1;
      if (ready && a_edge == 0) a_edge = e;
      if (b_ready && b_edge == 0) begin
        b_edge = e;
        b_wen0 = 1'b0;
      end
      if (a_edge != 0 && b_edge != 0) break;
    end
    checkOutput("a_ready_edge", 64'(a_edge), 64'd31);
    checkOutput("b_ready_edge", 64'(b_edge), 64'd8);
    checkOutput("a_init_reads_zero", 64'(init_bad), 64'd0);
    checkOutput("b_init_reads_zero", 64'(b_init_bad), 64'd0);

    for (int i = 0; i < 32; i++) begin
      v = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 32'h0, 32'h0};
      applyStimulus(v);
      checkOutput($sformatf("clear_rd1_%0d", i), rdata1, modelRead(5'(i)));
      checkOutput($sformatf("clear_rd2_%0d", 31 - i), rdata2, modelRead(5'(31 - i)));
      @(posedge clk);
    end
    v.raddr1 = 5'd3;
    applyStimulus(v);
    checkOutput("regs3_after_init", rdata1, 32'h0);
    checkOutput("ready_run", ready, 1'b1);
    @(posedge clk);

    $display("[TB] directed vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp1);
      checkOutput($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].exp2);
      @(posedge clk);
    end

    $display("[TB] random traffic against model");
    for (int n = 0; n < 300; n++) begin
      v = randomVec();
      applyStimulus(v);
      checkOutput("rand_rdata1", rdata1, modelRead(raddr1));
      checkOutput("rand_rdata2", rdata2, modelRead(raddr2));
      @(posedge clk);
    end

    $display("[TB] mid-operation reset");
    for (int i = 1; i < 32; i++) begin
      v = '{1'b1, 5'(i), $urandom | 32'h1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i), 32'h0, 32'h0};
      applyStimulus(v);
      @(posedge clk);
    end
    @(negedge clk);
    wen0 = 1'b0; wen1 = 1'b0; raddr1 = 5'd31; raddr2 = 5'd5;
    #1;
    checkOutput("filled_regs31_nonzero", 64'(rdata1 != 32'h0), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_ready", ready, 1'b0);
    checkOutput("midrst_rdata1", rdata1, 32'h0);
    checkOutput("midrst_rdata2", rdata2, 32'h0);
    rst_n = 1'b1;
    a_edge = 0; init_bad = 0;
    for (int e = 1; e <= 40; e++) begin
      v = randomVec();
      applyStimulus(v);
      if (!ready && (rdata1 !== 32'h0 || rdata2 !== 32'h0)) init_bad++;
      @(posedge clk);
      #1;
      if (ready) begin
        a_edge = e;
        break;
      end
    end
    checkOutput("midrst_ready_edge", 64'(a_edge), 64'd31);
    checkOutput("midrst_init_reads_zero", 64'(init_bad), 64'd0);
    for (int i = 0; i < 32; i++) begin
      v = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 32'h0, 32'h0};
      applyStimulus(v);
      checkOutput($sformatf("reclear_rd1_%0d", i), rdata1, 32'h0);
      checkOutput($sformatf("reclear_rd2_%0d", 31 - i), rdata2, 32'h0);
      @(posedge clk);
    end

    $display("[TB] wide instance without zero register");
    applyB(1'b1, 3'd0, 64'h0123456789ABCDEF, 1'b0, 3'd0, 64'h0, 3'd0, 3'd0);
    checkOutput("b_bypass_rd1", b_rdata1, 64'h0123456789ABCDEF);
    checkOutput("b_bypass_rd2", b_rdata2, 64'h0123456789ABCDEF);
    @(posedge clk);
    applyB(1'b0, 3'd0, 64'h0, 1'b0, 3'd0, 64'h0, 3'd0, 3'd2);
    checkOutput("b_stored_entry0", b_rdata1, 64'h0123456789ABCDEF);
    checkOutput("b_entry2_ignored_in_init", b_rdata2, 64'h0);
    @(posedge clk);
    applyB(1'b1, 3'd0, 64'h1111, 1'b1, 3'd0, 64'hFEDCBA9876543210, 3'd0, 3'd0);
    checkOutput("b_conflict_bypass_rd1", b_rdata1, 64'hFEDCBA9876543210);
    checkOutput("b_conflict_bypass_rd2", b_rdata2, 64'hFEDCBA9876543210);
    @(posedge clk);
    applyB(1'b0, 3'd0, 64'h0, 1'b0, 3'd0, 64'h0, 3'd0, 3'd5);
    checkOutput("b_conflict_stored", b_rdata1, 64'hFEDCBA9876543210);
    checkOutput("b_entry5_zero", b_rdata2, 64'h0);
    @(posedge clk);
    applyB(1'b1, 3'd6, 64'h66, 1'b1, 3'd5, 64'h55, 3'd5, 3'd6);
    checkOutput("b_dual_bypass_rd1", b_rdata1, 64'h55);
    checkOutput("b_dual_bypass_rd2", b_rdata2, 64'h66);
    @(posedge clk);
    applyB(1'b0, 3'd0, 64'h0, 1'b0, 3'd0, 64'h0, 3'd6, 3'd7);
    checkOutput("b_entry6_stored", b_rdata1, 64'h66);
    checkOutput("b_entry7_zero", b_rdata2, 64'h0);
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_2w2r.md
Name: reg_file_2w2r

Overview:
Next-generation general-purpose register file for the processor datapath, generalised in width and depth. It has two write ports with fixed priority and two read ports with same-cycle write-through bypass. After reset it clears its own storage with a one-entry-per-cycle sweep FSM and signals `ready` when the contents are valid. Register 0 can optionally be hardwired to zero.

Parameters:
- DATA_WIDTH, 32: width of each register and each data port.
- ADDR_WIDTH, 5: address width; DEPTH = 2**ADDR_WIDTH entries.
- ZERO_REG, 1: 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- wen0  input  1  write enable, port 0.
- waddr0  input  ADDR_WIDTH  write address, port 0.
- wdata0  input  DATA_WIDTH  write data, port 0.
- wen1  input  1  write enable, port 1 (higher priority).
- waddr1  input  ADDR_WIDTH  write address, port 1.
- wdata1  input  DATA_WIDTH  write data, port 1.
- raddr1  input  ADDR_WIDTH  read address, port 1.
- raddr2  input  ADDR_WIDTH  read address, port 2.
- rdata1  output  DATA_WIDTH  read data, port 1 (combinational).
- rdata2  output  DATA_WIDTH  read data, port 2 (combinational).
- ready  output  1  high once the clear sweep has completed.

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is synchronous and active-low, sampled only on the rising edge of `clk`.
- FSM states: INIT and RUN.
  - rst_n=0 at an edge: state <= INIT, sweep counter <= START (START = 1 if ZERO_REG, else 0), ready <= 0.
  - INIT with rst_n=1: each edge writes 0 to regs[counter] and increments the counter.
  - At the edge that clears entry DEPTH-1, state <= RUN and ready <= 1.
  - ready therefore rises DEPTH-START edges after the first edge with rst_n=1 (31 edges at defaults).
- Reset mid-operation: rst_n=0 in either state restarts the sweep from START. Contents are not instantly cleared; they are zeroed by the sweep.
- In INIT:
  - wen0 and wen1 are ignored.
  - rdata1 and rdata2 are forced to 0.
- Writes in RUN, on the rising edge:
  - wen1 writes wdata1 to regs[waddr1].
  - wen0 writes wdata0 to regs[waddr0].
  - If both are enabled and waddr0==waddr1, only wdata1 is stored.
  - If ZERO_REG=1, a write to address 0 is discarded (the other port still writes normally).
- Reads in RUN are combinational with no register latency. Priority for rdataN:
  1. If ZERO_REG=1 and raddrN==0: 0.
  2. Else if wen1 and waddr1==raddrN: wdata1 (bypass).
  3. Else if wen0 and waddr0==raddrN: wdata0 (bypass).
  4. Else regs[raddrN].
  - Bypass is not applied to a write that is discarded (address 0 with ZERO_REG=1).
- Both read ports may address the same entry, and may be bypassed simultaneously from different write ports.
- The sweep counter is ADDR_WIDTH+1 bits wide so the terminal compare cannot wrap. No other arithmetic.
- There are no X outputs after reset: rdata is 0 during INIT, and every entry has been cleared by the time RUN is reached.

Test Plan:
1. Hold rst_n=0 for 3 edges, release -> ready=0 for exactly 31 edges, then ready=1. Read all 32 entries -> all 0x00000000. rdata1/rdata2 are 0 throughout INIT even with wen1=1, waddr1=3, wdata1=0xDEADBEEF driven (and regs[3]=0 afterwards).
2. In RUN: wen0=1, waddr0=5, wdata0=0x12345678, raddr1=5 in the same cycle -> rdata1=0x12345678 before the edge (bypass). Next cycle with wen0=0 -> rdata1 still 0x12345678 (stored).
3. Same-address conflict: wen0=1, wen1=1, waddr0=waddr1=7, wdata0=0xAAAA0000, wdata1=0x5555FFFF -> same-cycle rdata2 (raddr2=7) = 0x5555FFFF; after the edge regs[7]=0x5555FFFF.
4. ZERO_REG=1: wen1=1, waddr1=0, wdata1=0xFFFFFFFF, raddr1=0 -> rdata1=0 in that cycle and afterwards. Concurrently wen0=1, waddr0=9 with wdata0=0x11 -> regs[9]=0x11.
5. Mid-operation reset: fill regs[1..31] with nonzero values, pulse rst_n=0 for 1 edge -> ready=0 immediately after the edge, reads return 0 during INIT, and after 31 edges all entries read 0.
6. Parameter sweep: DATA_WIDTH=64, ADDR_WIDTH=3, ZERO_REG=0 -> ready after 8 edges. A write of 0x0123456789ABCDEF to entry 0 reads back intact, and dual-port bypass on raddr1=raddr2=0 returns the same value on both ports.
